mips_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that owns the HI/LO architectural registers. It replaces the single-cycle combinational HI/LO path in the CPU datapath. The decoder issues a one-cycle start with an op code. The unit runs multi-cycle, raises busy, then commits HI/LO and pulses done. The core stalls MFHI/MFLO and further HI/LO ops while busy is high.

---
 rtl/mips_muldiv_pkg.sv | 52 +++++
 rtl/mips_muldiv_if.sv | 18 +
 rtl/mips_muldiv_iter.sv | 36 +++
 rtl/mips_muldiv_unit.sv | 148 ++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared types and op-decode helpers for the HI/LO multiply/divide unit.
// Optional accumulate ops are enabled by defining MIPS_MULDIV_MADD_EN.
package mips_muldiv_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_DIV   = 4'd2,
    OP_DIVU  = 4'd3,
    OP_MTHI  = 4'd4,
    OP_MTLO  = 4'd5,
    OP_MADD  = 4'd6,
    OP_MADDU = 4'd7,
    OP_MSUB  = 4'd8,
    OP_MSUBU = 4'd9
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX
  } muldiv_state_t;

  // Accumulate codes only count as multiplies when the feature is built in.
  function automatic logic is_mult_op(input muldiv_op_t op);
    case (op)
      OP_MULT, OP_MULTU: return 1'b1;
`ifdef MIPS_MULDIV_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_acc_op(input muldiv_op_t op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_sub_op(input muldiv_op_t op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Issue/result bundle between the decoder (master) and the mul/div unit (slave).
interface mips_muldiv_if
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  muldiv_op_t       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, rs_data, rt_data, input busy, done, hi, lo);
  modport slave  (input start, op, rs_data, rt_data, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_iter.sv
// One iteration of the mul/div datapath: radix-2^MUL_STEP shift-add for
// multiply, restoring shift-subtract for divide. Purely combinational.
module mips_muldiv_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             mul_mode,
  input  logic [WIDTH-1:0] cur_hi,
  input  logic [WIDTH-1:0] cur_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);
  logic [WIDTH+MUL_STEP-1:0] pp;
  logic [WIDTH+MUL_STEP-1:0] sum;
  logic [WIDTH:0]            shifted;
  logic [WIDTH:0]            diff;

  always_comb begin
    pp = '0;
    for (int i = 0; i < MUL_STEP; i++) begin
      if (cur_lo[i]) pp = pp + ({{MUL_STEP{1'b0}}, operand} << i);
    end
    sum     = {{MUL_STEP{1'b0}}, cur_hi} + pp;
    // Partial remainder stays below the divisor, so bit WIDTH of diff is the borrow.
    shifted = {cur_hi, cur_lo[WIDTH-1]};
    diff    = shifted - {1'b0, operand};
    if (mul_mode) begin
      next_hi = sum[WIDTH+MUL_STEP-1:MUL_STEP];
      next_lo = {sum[MUL_STEP-1:0], cur_lo[WIDTH-1:MUL_STEP]};
    end else begin
      next_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      next_lo = {cur_lo[WIDTH-2:0], ~diff[WIDTH]};
    end
  end
endmodule

// File: rtl/mips_muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: IDLE -> PREP -> ITER x N -> FIX.
// Define MIPS_MULDIV_MADD_EN to add MADD/MADDU/MSUB/MSUBU accumulation.
module mips_muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_enable,
  mips_muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int N_MUL = WIDTH / MUL_STEP;
  localparam int N_DIV = WIDTH;

  muldiv_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  muldiv_op_t       op_q;
  logic [WIDTH-1:0] a_raw, b_raw;
  logic [WIDTH-1:0] w_hi, w_lo, w_b;
  logic             neg_res, neg_rem;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] it_hi, it_lo;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             accept, mt_hi, mt_lo;
  logic             a_neg, b_neg;
  logic signed [WIDTH-1:0]   a_s, b_s;
  logic [2*WIDTH-1:0]        prod;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_if2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign accept = (state == ST_IDLE) && bus.start && (is_mult_op(bus.op) || is_div_op(bus.op));
  assign mt_hi  = (state == ST_IDLE) && bus.start && (bus.op == OP_MTHI);
  assign mt_lo  = (state == ST_IDLE) && bus.start && (bus.op == OP_MTLO);

  assign a_s    = a_raw;
  assign b_s    = b_raw;
  assign a_neg  = is_signed_op(op_q) && (a_s < 0);
  assign b_neg  = is_signed_op(op_q) && (b_s < 0);

  mips_muldiv_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_iter (
    .mul_mode (is_mult_op(op_q)),
    .cur_hi   (w_hi),
    .cur_lo   (w_lo),
    .operand  (w_b),
    .next_hi  (it_hi),
    .next_lo  (it_lo)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_PREP;
      ST_PREP: state_nxt = ST_ITER;
      ST_ITER: if (cnt == CNT_W'(1)) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
    end else if (clk_enable) begin
      state  <= state_nxt;
      done_q <= (state == ST_FIX);
      if (state == ST_PREP) cnt <= is_mult_op(op_q) ? CNT_W'(N_MUL) : CNT_W'(N_DIV);
      else if (state == ST_ITER) cnt <= cnt - CNT_W'(1);
    end
  end

  // Working datapath: hi/lo hold partial product or remainder/quotient, w_b the other magnitude.
  always_ff @(posedge clk) begin
    if (clk_enable) begin
      case (state)
        ST_IDLE: if (accept) begin
          a_raw <= bus.rs_data;
          b_raw <= bus.rt_data;
          op_q  <= bus.op;
        end
        ST_PREP: begin
          w_hi    <= '0;
          w_lo    <= neg_if(a_raw, a_neg);
          w_b     <= neg_if(b_raw, b_neg);
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
        end
        ST_ITER: begin
          w_hi <= it_hi;
          w_lo <= it_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    prod   = neg_if2({w_hi, w_lo}, neg_res);
    fix_hi = prod[2*WIDTH-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (!is_mult_op(op_q)) begin
      if (b_raw == '0) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = neg_if(w_hi, neg_rem);
        fix_lo = neg_if(w_lo, neg_res);
      end
    end
`ifdef MIPS_MULDIV_MADD_EN
    else if (is_acc_op(op_q)) begin
      {fix_hi, fix_lo} = is_sub_op(op_q) ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (clk_enable) begin
      if (state == ST_FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end else if (mt_hi) begin
        hi_q <= bus.rs_data;
      end else if (mt_lo) begin
        lo_q <= bus.rs_data;
      end
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: one MUL_STEP=1 instance, one MUL_STEP=4 instance.
module tb_mips_muldiv_unit;
  import mips_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  int   total = 0;
  int   bad = 0;

  mips_muldiv_if #(.WIDTH(32)) b1 ();
  mips_muldiv_if #(.WIDTH(32)) b4 ();

  mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .clk_enable(en), .bus(b1)
  );
  mips_muldiv_unit #(.WIDTH(32), .MUL_STEP(4)) dut4 (
    .clk(clk), .reset(reset), .clk_enable(en), .bus(b4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    b1.start = 1'b1; b1.op = o; b1.rs_data = a; b1.rt_data = b;
    tick();
    b1.start = 1'b0;
  endtask

  // Issues in cycle 0 and returns in the done cycle N+3.
  task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] ehi, input logic [31:0] elo);
    issue(o, a, b);
    chk({tag, "_busy_c1"}, b1.busy, 1);
    repeat (n + 1) tick();
    chk({tag, "_busy_last"}, b1.busy, 1);
    chk({tag, "_done_early"}, b1.done, 0);
    tick();
    chk({tag, "_busy_end"}, b1.busy, 0);
    chk({tag, "_done"}, b1.done, 1);
    chk({tag, "_hi"}, b1.hi, ehi);
    chk({tag, "_lo"}, b1.lo, elo);
  endtask

  initial begin
    logic seen_done;
    b1.start = 0; b1.op = OP_MULT; b1.rs_data = 0; b1.rt_data = 0;
    b4.start = 0; b4.op = OP_MULT; b4.rs_data = 0; b4.rt_data = 0;
    repeat (2) tick();
    chk("rst_busy", b1.busy, 0);
    chk("rst_done", b1.done, 0);
    chk("rst_hi", b1.hi, 0);
    chk("rst_lo", b1.lo, 0);
    reset = 1'b0;
    tick();

    // MUL_STEP=4: N=8, done in cycle 11
    b4.start = 1; b4.op = OP_MULTU; b4.rs_data = 32'hFFFFFFFF; b4.rt_data = 32'hFFFFFFFF;
    tick();
    b4.start = 0;
    chk("m4u_busy_c1", b4.busy, 1);
    repeat (9) tick();
    chk("m4u_busy_c10", b4.busy, 1);
    chk("m4u_done_c10", b4.done, 0);
    tick();
    chk("m4u_done_c11", b4.done, 1);
    chk("m4u_busy_c11", b4.busy, 0);
    chk("m4u_hilo", {b4.hi, b4.lo}, 64'hFFFFFFFE_00000001);
    b4.start = 1; b4.op = OP_MULT; b4.rs_data = 32'hFFFFFFFD; b4.rt_data = 32'd7;
    tick();
    b4.start = 0;
    repeat (10) tick();
    chk("m4s_done_c11", b4.done, 1);
    chk("m4s_hilo", {b4.hi, b4.lo}, 64'hFFFFFFFF_FFFFFFEB);

    // MUL_STEP=1 instance, back-to-back issues in the done cycle
    run_op("mult", OP_MULT, 32'hFFFFFFFD, 32'd7, 32, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_z", OP_DIVU, 32'h80000000, 32'd0, 32, 32'h80000000, 32'hFFFFFFFF);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32, 32'h0, 32'h80000000);

    // DIVU 100/7 with a 5-cycle freeze and an MTHI while busy
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    issue(OP_MTHI, 32'hDEAD, 32'd0);
    repeat (4) tick();
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    chk("frz_busy", b1.busy, 1);
    chk("frz_hi", b1.hi, 0);
    repeat (24) tick();
    chk("frz_busy_c39", b1.busy, 1);
    chk("frz_done_c39", b1.done, 0);
    tick();
    chk("frz_done_c40", b1.done, 1);
    chk("frz_hi_c40", b1.hi, 2);
    chk("frz_lo_c40", b1.lo, 14);
    en = 1'b0;
    tick();
    chk("frz_done_hold", b1.done, 1);
    en = 1'b1;
    tick();
    chk("frz_done_drop", b1.done, 0);

    // MTLO in IDLE
    issue(OP_MTLO, 32'h1234, 32'd0);
    chk("mtlo_lo", b1.lo, 32'h1234);
    chk("mtlo_busy", b1.busy, 0);
    chk("mtlo_done", b1.done, 0);
    tick();
    chk("mtlo_done2", b1.done, 0);

    // Undefined op codes
    issue(muldiv_op_t'(4'd12), 32'd5, 32'd5);
    chk("undef12_busy", b1.busy, 0);
    chk("undef12_hilo", {b1.hi, b1.lo}, {32'd2, 32'h1234});
`ifndef MIPS_MULDIV_MADD_EN
    issue(OP_MADD, 32'd3, 32'd4);
    chk("undef6_busy", b1.busy, 0);
    tick();
    chk("undef6_hilo", {b1.hi, b1.lo}, {32'd2, 32'h1234});
`endif

    // Reset in cycle 10 of a DIV discards it
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_busy", b1.busy, 0);
    chk("rstmid_hilo", {b1.hi, b1.lo}, 64'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (b1.done) seen_done = 1'b1;
      tick();
    end
    chk("rstmid_no_done", seen_done, 0);

`ifdef MIPS_MULDIV_MADD_EN
    issue(OP_MTLO, 32'd5, 32'd0);
    issue(OP_MTHI, 32'd0, 32'd0);
    run_op("madd", OP_MADD, 32'd3, 32'd4, 32, 32'd0, 32'd17);
    run_op("msubu", OP_MSUBU, 32'hFFFFFFFF, 32'd2, 32, 32'hFFFFFFFE, 32'h00000013);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
